// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: single-clock FIFO built on a 2^L x DW two-port array with a registered read port.
//
// Parameters
//   L   address width, depth = 2^L words
//   DW  data width
//   AF  almost-full threshold (1..2^L), afull = (cnt >= AF)
//
// Ports
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   wd/we  write data / write request (accepted iff !full)
//   re     pop request (accepted iff !empty)
//   rd     read data register
//   full, empty, afull, cnt  registered status; cnt includes any prefetched output word
//   ovf/udf  sticky overflow/underflow, cleared only by reset
//
// Optional build macro: SYNC_FIFO_FWFT_EN
//   undefined: a pop loads rd with the head word, visible the cycle after the pop edge.
//   defined  : first-word-fall-through; rd holds the head word whenever empty=0.
module sync_fifo_ram #(
    parameter int unsigned L  = 8,
    parameter int unsigned DW = 6,
    parameter int unsigned AF = (2 ** L) - 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] wd,
    input  logic          we,
    input  logic          re,
    output logic [DW-1:0] rd,
    output logic          full,
    output logic          empty,
    output logic          afull,
    output logic [L:0]    cnt,
    output logic          ovf,
    output logic          udf
);

    localparam int unsigned Depth    = 2 ** L;
    localparam logic [L:0]  DepthCnt = (L + 1)'(Depth);
    localparam logic [L:0]  AfCnt    = (L + 1)'(AF);
    localparam logic [L:0]  One      = (L + 1)'(1);

    logic [DW-1:0] mem_q [Depth];

    logic [L:0]    wp_q, wp_d;
    logic [L:0]    rp_q, rp_d;
    logic [L:0]    cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;
    logic [DW-1:0] rd_q, rd_d;

    logic          push;
    logic          pop;
    logic          rd_load;

    always_comb begin
        push = we & ~full_q;
        pop  = re & ~empty_q;

`ifdef SYNC_FIFO_FWFT_EN
        // Refill the output register whenever it is consumed or idle and the array has a word.
        // A word written this edge is not yet readable from the array, hence the extra edge.
        rd_load = (wp_q != rp_q) & (pop | empty_q);
        empty_d = ~(rd_load | (~empty_q & ~pop));
`else
        rd_load = pop;
        empty_d = 1'b0;
`endif

        wp_d = push    ? wp_q + One : wp_q;
        rp_d = rd_load ? rp_q + One : rp_q;

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + One;
        end else if (pop && !push) begin
            cnt_d = cnt_q - One;
        end

`ifndef SYNC_FIFO_FWFT_EN
        empty_d = (cnt_d == '0);
`endif
        full_d  = (cnt_d == DepthCnt);
        afull_d = (cnt_d >= AfCnt);

        ovf_d = ovf_q | (we & full_q);
        udf_d = udf_q | (re & empty_q);

        rd_d = rd_load ? mem_q[rp_q[L-1:0]] : rd_q;
    end

    // Array contents are deliberately not reset; writes are suppressed during reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wp_q[L-1:0]] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            afull_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            afull_q <= afull_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            rd_q    <= rd_d;
        end
    end

    assign rd    = rd_q;
    assign full  = full_q;
    assign empty = empty_q;
    assign afull = afull_q;
    assign cnt   = cnt_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule
